// File: rtl/pipe_drain_fifo_if.sv
// Handshake bundle between a valid-tagged pipeline, its credit source
// and the downstream consumer of the drained results.
interface pipe_drain_fifo_if #(
    parameter int width = 8,
    parameter int depth = 8
);
    logic                         issue_vld;
    logic                         issue_rdy;
    logic                         pipe_vld;
    logic [width-1:0]             pipe_data;
    logic                         out_vld;
    logic                         out_rdy;
    logic [width-1:0]             out_data;
    logic [$clog2(depth+1)-1:0]   count;
    logic                         overflow;

    modport master (
        output issue_vld,
        output pipe_vld,
        output pipe_data,
        output out_rdy,
        input  issue_rdy,
        input  out_vld,
        input  out_data,
        input  count,
        input  overflow
    );

    modport slave (
        input  issue_vld,
        input  pipe_vld,
        input  pipe_data,
        input  out_rdy,
        output issue_rdy,
        output out_vld,
        output out_data,
        output count,
        output overflow
    );
endinterface

// File: rtl/pipe_drain_fifo.sv
// Drains a no-back-pressure pipeline into a FIFO and hands out credits
// so that every in-flight item is guaranteed a slot when it lands.
module pipe_drain_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_drain_fifo_if.slave  bus
);
    localparam int CW = $clog2(depth + 1);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t FULL_C = cnt_t'(depth);
    localparam ptr_t LAST_P = ptr_t'(depth - 1);

    logic [width-1:0] mem_q [depth];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t occ_q, occ_d;
    cnt_t rsv_q, rsv_d;
    logic ovf_q, ovf_d;

    logic pop;
    logic take;
    logic free;
    logic wr;
    logic rel;

    // Wrap by compare so non-power-of-two depths stay in range.
    function automatic ptr_t bump(input ptr_t p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop  = (occ_q != '0) & bus.out_rdy;
        take = bus.issue_vld & (rsv_q != FULL_C);
        free = (occ_q != FULL_C) | pop;
        wr   = bus.pipe_vld & free;
        rel  = pop & (rsv_q != '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        rsv_d    = rsv_q;
        ovf_d    = ovf_q | (bus.pipe_vld & ~free);

        if (wr)
            wr_ptr_d = bump(wr_ptr_q);
        if (pop)
            rd_ptr_d = bump(rd_ptr_q);

        unique case (1'b1)
            wr & ~pop: occ_d = occ_q + 1'b1;
            pop & ~wr: occ_d = occ_q - 1'b1;
            default:   occ_d = occ_q;
        endcase

        unique case (1'b1)
            take & ~rel: rsv_d = rsv_q + 1'b1;
            rel & ~take: rsv_d = rsv_q - 1'b1;
            default:     rsv_d = rsv_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rsv_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rsv_q    <= rsv_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (wr)
            mem_q[wr_ptr_q] <= bus.pipe_data;
    end

    assign bus.issue_rdy = (rsv_q != FULL_C);
    assign bus.out_vld   = (occ_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = occ_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Bench: queue-level model of the drain FIFO plus credit count, checked
// every cycle, with directed scenarios and randomized pipeline streams.
module tb_pipe_drain_fifo;
    localparam int D = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_drain_fifo_if #(.width(W), .depth(D)) b4();
    pipe_drain_fifo_if #(.width(W), .depth(8)) b8();

    pipe_drain_fifo #(.width(W), .depth(D)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );
    pipe_drain_fifo #(.width(W), .depth(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    int m_rsv = 0;
    bit m_ovf = 0;
    bit ord_en = 0;
    int ord_exp = 0;
    int rcv = 0;
    logic [7:0] sched[int];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle4();
        b4.issue_vld = 0;
        b4.pipe_vld  = 0;
        b4.pipe_data = 0;
        b4.out_rdy   = 0;
    endtask

    // Model: FIFO contents as a queue, credits as an integer.
    always @(negedge clk) begin
        int occ;
        bit pop;
        bit iss;
        bit free;
        if (!rst_n) begin
            mq.delete();
            m_rsv = 0;
            m_ovf = 0;
            chk("rst_out_vld", b4.out_vld, 0);
            chk("rst_count", b4.count, 0);
            chk("rst_overflow", b4.overflow, 0);
            chk("rst_issue_rdy", b4.issue_rdy, 1);
        end else begin
            occ = mq.size();
            chk("out_vld", b4.out_vld, occ != 0);
            if (occ != 0)
                chk("out_data", b4.out_data, mq[0]);
            chk("count", b4.count, occ);
            chk("overflow", b4.overflow, m_ovf);
            chk("issue_rdy", b4.issue_rdy, m_rsv < D);
            pop  = (occ != 0) && (b4.out_rdy === 1'b1);
            iss  = (b4.issue_vld === 1'b1) && (m_rsv < D);
            free = (occ < D) || pop;
            if (ord_en && pop) begin
                chk("order", b4.out_data, ord_exp);
                ord_exp++;
                rcv++;
            end
            if (pop)
                void'(mq.pop_front());
            if (b4.pipe_vld === 1'b1) begin
                if (free)
                    mq.push_back(b4.pipe_data);
                else
                    m_ovf = 1;
            end
            if (iss)
                m_rsv++;
            if (pop && m_rsv > 0)
                m_rsv--;
        end
    end

    // Fixed-latency pipeline emulation fed only by accepted issues.
    task automatic stream(input int n, input int lat, input bit seq,
                          input int budget);
        int issued = 0;
        int cyc = 0;
        logic [7:0] nd = 8'h01;
        sched.delete();
        while ((issued < n || sched.num() > 0 || mq.size() > 0)
               && cyc < budget) begin
            b4.pipe_vld = sched.exists(cyc);
            if (b4.pipe_vld) begin
                b4.pipe_data = sched[cyc];
                sched.delete(cyc);
            end else begin
                b4.pipe_data = 8'($urandom);
            end
            b4.issue_vld = (issued < n) && ($urandom_range(0, 3) != 0);
            b4.out_rdy = 1'($urandom_range(0, 1));
            if (b4.issue_vld && b4.issue_rdy) begin
                sched[cyc + lat] = seq ? nd : 8'($urandom);
                nd++;
                issued++;
            end
            tick();
            cyc++;
        end
        idle4();
        chk("stream_budget", cyc < budget, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        idle4();
        b8.issue_vld = 0;
        b8.pipe_vld  = 0;
        b8.pipe_data = 0;
        b8.out_rdy   = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        chk("rst4_vld", b4.out_vld, 0);
        chk("rst4_rdy", b4.issue_rdy, 1);
        chk("rst8_vld", b8.out_vld, 0);
        chk("rst8_cnt", b8.count, 0);
        chk("rst8_ovf", b8.overflow, 0);
        chk("rst8_rdy", b8.issue_rdy, 1);

        // single item through an 8-deep instance, latency 8
        b8.issue_vld = 1;
        tick();
        b8.issue_vld = 0;
        chk("d8_rdy_after_issue", b8.issue_rdy, 1);
        repeat (7) tick();
        chk("d8_empty_before", b8.out_vld, 0);
        b8.pipe_vld = 1;
        b8.pipe_data = 8'hA5;
        tick();
        b8.pipe_vld = 0;
        chk("d8_vld", b8.out_vld, 1);
        chk("d8_data", b8.out_data, 8'hA5);
        chk("d8_count", b8.count, 1);
        b8.out_rdy = 1;
        tick();
        b8.out_rdy = 0;
        chk("d8_popped_vld", b8.out_vld, 0);
        chk("d8_popped_cnt", b8.count, 0);

        // credit exhaustion
        b4.issue_vld = 1;
        repeat (3) tick();
        chk("cr_rdy_3", b4.issue_rdy, 1);
        tick();
        chk("cr_rdy_4", b4.issue_rdy, 0);
        tick();
        b4.issue_vld = 0;
        chk("cr_rdy_ignored", b4.issue_rdy, 0);
        for (int i = 0; i < 4; i++) begin
            b4.pipe_vld = 1;
            b4.pipe_data = 8'(8'h10 + i);
            tick();
        end
        b4.pipe_vld = 0;
        chk("cr_count", b4.count, 4);
        chk("cr_ovf", b4.overflow, 0);
        chk("cr_head", b4.out_data, 8'h10);
        b4.out_rdy = 1;
        tick();
        b4.out_rdy = 0;
        chk("cr_rdy_back", b4.issue_rdy, 1);
        chk("cr_count3", b4.count, 3);

        // issue and pop together at three credits
        b4.issue_vld = 1;
        b4.out_rdy = 1;
        tick();
        idle4();
        chk("sim_rdy", b4.issue_rdy, 1);
        chk("sim_count", b4.count, 2);
        chk("sim_head", b4.out_data, 8'h12);
        b4.issue_vld = 1;
        tick();
        b4.issue_vld = 0;
        chk("sim_rdy_full", b4.issue_rdy, 0);
        for (int i = 0; i < 2; i++) begin
            b4.pipe_vld = 1;
            b4.pipe_data = 8'(8'h20 + i);
            tick();
        end
        b4.pipe_vld = 0;
        chk("sim_full", b4.count, 4);
        b4.pipe_vld = 1;
        b4.pipe_data = 8'h22;
        b4.out_rdy = 1;
        tick();
        idle4();
        chk("sim_wr_pop_cnt", b4.count, 4);
        chk("sim_wr_pop_ovf", b4.overflow, 0);
        chk("sim_wr_pop_head", b4.out_data, 8'h13);

        // overflow on a full FIFO
        b4.pipe_vld = 1;
        b4.pipe_data = 8'hEE;
        tick();
        idle4();
        chk("ovf_count", b4.count, 4);
        chk("ovf_head", b4.out_data, 8'h13);
        chk("ovf_set", b4.overflow, 1);
        repeat (20) tick();
        chk("ovf_sticky", b4.overflow, 1);
        b4.out_rdy = 1;
        tick();
        b4.out_rdy = 0;

        // asynchronous reset mid-cycle with three items held
        @(posedge clk);
        #2;
        chk("arst_pre_cnt", b4.count, 3);
        #1 rst_n = 0;
        #1;
        chk("arst_vld", b4.out_vld, 0);
        chk("arst_cnt", b4.count, 0);
        chk("arst_ovf", b4.overflow, 0);
        chk("arst_rdy", b4.issue_rdy, 1);
        repeat (3) tick();
        rst_n = 1;
        tick();
        chk("arst_rel_vld", b4.out_vld, 0);
        chk("arst_rel_rdy", b4.issue_rdy, 1);

        // ordered stream with wrap-around
        ord_exp = 1;
        rcv = 0;
        ord_en = 1;
        stream(10, 6, 1, 600);
        tick();
        ord_en = 0;
        chk("order_received", rcv, 10);
        chk("order_ovf", b4.overflow, 0);

        // randomized streams, various latencies
        for (int k = 0; k < 4; k++)
            stream(60, $urandom_range(1, 9), 0, 2000);
        tick();
        chk("rand_ovf", b4.overflow, 0);
        chk("rand_drained", b4.count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
